// File: rtl/lsu.sv
// Load/store unit: one data-RAM transaction per request over a req/ack bus, with lane steering and load extension.
// Build option LSU_MISALIGN_SPLIT_EN: split misaligned accesses in hardware instead of rejecting them.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lsu_start_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] rs2_rd_data_i,
  output logic            dram_req_o,
  output logic            dram_we_o,
  output logic [XLEN-1:0] dram_addr_o,
  output logic [XLEN-1:0] dram_wr_data_o,
  output logic [3:0]      dram_wr_byte_en_o,
  input  logic            dram_ack_i,
  input  logic [XLEN-1:0] dram_rd_data_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic            lsu_misalign_o,
  output logic [XLEN-1:0] lsu_rd_data_o
);

  typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_t;

  state_t          state;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            we_q;
  logic            split_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] beat0_q;

  logic [1:0]      off_c;
  logic [3:0]      mask_c;
  logic [3:0]      be0_c;
  logic            split_c;
  logic            reject_c;
  logic [3:0]      mask_q;
  logic [3:0]      be1_c;
  logic [2:0]      hi_bytes_c;
  logic [XLEN-1:0] wr1_c;
  logic [63:0]     beats_c;
  logic [XLEN-1:0] sh_c;
  logic [XLEN-1:0] load_c;
  logic            last_beat_c;

  assign off_c = alu_data_i[1:0];

  always_comb begin
    mask_c = 4'b1111;
    case (lsu_size_i)
      2'b00:   mask_c = 4'b0001;
      2'b01:   mask_c = 4'b0011;
      default: mask_c = 4'b1111;
    endcase
  end

  assign be0_c = mask_c << off_c;

`ifdef LSU_MISALIGN_SPLIT_EN
  // off + size_bytes > 4: bytes never split, halves only at off=3, words at any nonzero offset
  always_comb begin
    split_c  = 1'b0;
    reject_c = 1'b0;
    case (lsu_size_i)
      2'b00:   split_c = 1'b0;
      2'b01:   split_c = (off_c == 2'b11);
      default: split_c = (off_c != 2'b00);
    endcase
  end
`else
  always_comb begin
    split_c  = 1'b0;
    reject_c = 1'b0;
    case (lsu_size_i)
      2'b00:   reject_c = 1'b0;
      2'b01:   reject_c = off_c[0];
      default: reject_c = (off_c != 2'b00);
    endcase
  end
`endif

  // Second-beat lane terms come from the captured request
  always_comb begin
    mask_q = 4'b1111;
    case (size_q)
      2'b00:   mask_q = 4'b0001;
      2'b01:   mask_q = 4'b0011;
      default: mask_q = 4'b1111;
    endcase
  end

  assign hi_bytes_c = 3'd4 - {1'b0, off_q};
  assign be1_c      = mask_q >> hi_bytes_c;
  assign wr1_c      = rs2_q >> {hi_bytes_c, 3'b000};

  assign beats_c = (state == REQ1) ? {dram_rd_data_i, beat0_q} : {32'b0, dram_rd_data_i};
  assign sh_c    = XLEN'(beats_c >> {off_q, 3'b000});

  always_comb begin
    load_c = sh_c;
    case (size_q)
      2'b00:   load_c = uns_q ? {24'b0, sh_c[7:0]}  : {{24{sh_c[7]}}, sh_c[7:0]};
      2'b01:   load_c = uns_q ? {16'b0, sh_c[15:0]} : {{16{sh_c[15]}}, sh_c[15:0]};
      default: load_c = sh_c;
    endcase
  end

  assign last_beat_c = dram_ack_i && ((state == REQ1) || ((state == REQ0) && !split_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      off_q             <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      we_q              <= 1'b0;
      split_q           <= 1'b0;
      rs2_q             <= '0;
      beat0_q           <= '0;
      dram_req_o        <= 1'b0;
      dram_we_o         <= 1'b0;
      dram_addr_o       <= '0;
      dram_wr_data_o    <= '0;
      dram_wr_byte_en_o <= '0;
      lsu_busy_o        <= 1'b0;
      lsu_done_o        <= 1'b0;
      lsu_misalign_o    <= 1'b0;
      lsu_rd_data_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_start_i) begin
            off_q      <= off_c;
            size_q     <= lsu_size_i;
            uns_q      <= lsu_unsigned_i;
            we_q       <= lsu_we_i;
            split_q    <= split_c;
            rs2_q      <= rs2_rd_data_i;
            lsu_busy_o <= 1'b1;
            if (reject_c) begin
              state          <= DONE;
              lsu_done_o     <= 1'b1;
              lsu_misalign_o <= 1'b1;
            end else begin
              state             <= REQ0;
              dram_req_o        <= 1'b1;
              dram_we_o         <= lsu_we_i;
              dram_addr_o       <= {alu_data_i[XLEN-1:2], 2'b00};
              dram_wr_byte_en_o <= be0_c;
              dram_wr_data_o    <= rs2_rd_data_i << {off_c, 3'b000};
            end
          end
        end
        REQ0: begin
          if (dram_ack_i) begin
            beat0_q <= dram_rd_data_i;
            if (split_q) begin
              state             <= REQ1;
              dram_addr_o       <= dram_addr_o + 32'd4;
              dram_wr_byte_en_o <= be1_c;
              dram_wr_data_o    <= wr1_c;
            end
          end
        end
        REQ1: begin
        end
        DONE: begin
          state          <= IDLE;
          lsu_busy_o     <= 1'b0;
          lsu_done_o     <= 1'b0;
          lsu_misalign_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (last_beat_c) begin
        state             <= DONE;
        dram_req_o        <= 1'b0;
        dram_we_o         <= 1'b0;
        dram_wr_byte_en_o <= '0;
        lsu_done_o        <= 1'b1;
        if (!we_q) lsu_rd_data_o <= load_c;
      end
    end
  end

endmodule
